// File: rtl/cra_sequencer.sv
// cra_sequencer: microcode next-address sequencer with return stack and FETCH/EXEC handshake.
// Define CRA_STACK_CHECK_EN to saturate the stack on overflow/underflow and flag sticky STK_ERR.
module cra_sequencer #(
   parameter int STACK_DEPTH = 16
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        START,
   input  logic [11:0] START_ADR,
   input  logic        HALT,
   input  logic        MB_WAIT,
   input  logic [11:0] J,
   input  logic        CALL,
   input  logic [1:0]  DISP_MODE,
   input  logic [3:0]  DISP_DATA,
   input  logic        SKIP_EN,
   input  logic        SKIP_COND,
   output logic [11:0] CRADR,
   output logic        UINST_VALID,
   output logic        RUNNING,
   output logic [6:0]  STK_DEPTH,
   output logic        STK_ERR
);
   localparam int AW = $clog2(STACK_DEPTH);
   localparam int PW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;

   localparam logic [1:0] DM_OR  = 2'd1;
   localparam logic [1:0] DM_RET = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] sp, sp_mid, sp_nxt;
   logic [11:0]   stk [STACK_DEPTH];
   logic [11:0]   pop_val, nxt_adr;
   logic [AW-1:0] push_idx;
   logic          push_we, ret, adv;
`ifdef CRA_STACK_CHECK_EN
   logic          err_set;
`endif

   assign ret       = (DISP_MODE == DM_RET);
   assign adv       = (state == S_EXEC) && !MB_WAIT && !START;
   assign STK_DEPTH = 7'(sp);

   always_comb begin
      state_nxt = state;
      if (START)
         state_nxt = S_FETCH;
      else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  if (!MB_WAIT) state_nxt = HALT ? S_IDLE : S_FETCH;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // A call+return word pops first, then pushes into the slot just vacated.
   always_comb begin
      sp_mid   = sp;
      pop_val  = '0;
      push_we  = 1'b0;
      push_idx = sp[AW-1:0];
`ifdef CRA_STACK_CHECK_EN
      err_set = 1'b0;
      if (ret) begin
         if (sp == '0)
            err_set = 1'b1;
         else begin
            sp_mid  = sp - PW'(1);
            pop_val = stk[sp_mid[AW-1:0]];
         end
      end
      sp_nxt = sp_mid;
      if (CALL) begin
         if (sp_mid == PW'(STACK_DEPTH))
            err_set = 1'b1;
         else begin
            push_we  = 1'b1;
            push_idx = sp_mid[AW-1:0];
            sp_nxt   = sp_mid + PW'(1);
         end
      end
`else
      if (ret) begin
         sp_mid  = {1'b0, sp[AW-1:0] - AW'(1)};
         pop_val = stk[sp_mid[AW-1:0]];
      end
      sp_nxt = sp_mid;
      if (CALL) begin
         push_we  = 1'b1;
         push_idx = sp_mid[AW-1:0];
         sp_nxt   = {1'b0, sp_mid[AW-1:0] + AW'(1)};
      end
`endif
   end

   always_comb begin
      if (ret)
         nxt_adr = pop_val | {8'b0, DISP_DATA};
      else begin
         nxt_adr    = (DISP_MODE == DM_OR) ? (J | {8'b0, DISP_DATA}) : J;
         nxt_adr[0] = nxt_adr[0] | (SKIP_EN & SKIP_COND);
      end
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state       <= S_IDLE;
         CRADR       <= '0;
         sp          <= '0;
         UINST_VALID <= 1'b0;
         RUNNING     <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      end else begin
         state       <= state_nxt;
         UINST_VALID <= (state_nxt == S_EXEC);
         RUNNING     <= (state_nxt != S_IDLE);
         if (START) begin
            CRADR <= START_ADR;
            sp    <= '0;
         end else if (adv) begin
            CRADR <= nxt_adr;
            sp    <= sp_nxt;
            if (push_we) stk[push_idx] <= CRADR;
         end
      end
   end

`ifdef CRA_STACK_CHECK_EN
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET)
         STK_ERR <= 1'b0;
      else if (adv && err_set)
         STK_ERR <= 1'b1;
   end
`else
   assign STK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cra_sequencer.sv
// Directed bench for cra_sequencer: reset, jump/skip/dispatch, stalls, call/return, stack limits, halt, restart.
module tb_cra_sequencer;
   logic        clk = 1'b0;
   logic        RESET, START, HALT, MB_WAIT, CALL, SKIP_EN, SKIP_COND;
   logic [11:0] START_ADR, J;
   logic [1:0]  DISP_MODE;
   logic [3:0]  DISP_DATA;
   logic [11:0] CRADR;
   logic        UINST_VALID, RUNNING, STK_ERR;
   logic [6:0]  STK_DEPTH;

   int vectors = 0;
   int miscompares = 0;

   cra_sequencer #(.STACK_DEPTH(16)) dut (
      .clk(clk), .RESET(RESET), .START(START), .START_ADR(START_ADR),
      .HALT(HALT), .MB_WAIT(MB_WAIT), .J(J), .CALL(CALL),
      .DISP_MODE(DISP_MODE), .DISP_DATA(DISP_DATA), .SKIP_EN(SKIP_EN),
      .SKIP_COND(SKIP_COND), .CRADR(CRADR), .UINST_VALID(UINST_VALID),
      .RUNNING(RUNNING), .STK_DEPTH(STK_DEPTH), .STK_ERR(STK_ERR)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fields();
      J = '0; CALL = 1'b0; DISP_MODE = 2'd0; DISP_DATA = '0;
      SKIP_EN = 1'b0; SKIP_COND = 1'b0; HALT = 1'b0; MB_WAIT = 1'b0;
   endtask

   task automatic do_start(input logic [11:0] adr);
      START_ADR = adr; START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Runs one microinstruction starting from FETCH; leaves the sequencer in the next FETCH.
   task automatic uop(input logic [11:0] j, input logic call, input logic [1:0] mode,
                      input logic [3:0] data, input logic sen, input logic scond);
      J = j; CALL = call; DISP_MODE = mode; DISP_DATA = data;
      SKIP_EN = sen; SKIP_COND = scond;
      step();
      step();
      clear_fields();
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; START_ADR = '0; clear_fields();
      step(); step();
      RESET = 1'b0;
      step();
      vectors++; if (CRADR !== 12'o0) begin miscompares++; $display("FAIL reset_cradr: got %o want 0", CRADR); end
      vectors++; if (UINST_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_uvalid: got %b want 0", UINST_VALID); end
      vectors++; if (RUNNING !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b want 0", RUNNING); end
      vectors++; if (STK_DEPTH !== 7'd0) begin miscompares++; $display("FAIL reset_depth: got %0d want 0", STK_DEPTH); end
      vectors++; if (STK_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", STK_ERR); end
      // Idle ignores microword fields
      J = 12'o7777; step(); J = '0;
      vectors++; if (CRADR !== 12'o0) begin miscompares++; $display("FAIL idle_hold: got %o want 0", CRADR); end
   endtask

   task automatic test_start_jump();
      do_start(12'o0100);
      vectors++; if (CRADR !== 12'o0100) begin miscompares++; $display("FAIL start_cradr: got %o want 100", CRADR); end
      vectors++; if (UINST_VALID !== 1'b0) begin miscompares++; $display("FAIL start_fetch_uv: got %b want 0", UINST_VALID); end
      vectors++; if (RUNNING !== 1'b1) begin miscompares++; $display("FAIL start_running: got %b want 1", RUNNING); end
      J = 12'o0200;
      step();
      vectors++; if (UINST_VALID !== 1'b1) begin miscompares++; $display("FAIL exec_uv: got %b want 1", UINST_VALID); end
      vectors++; if (CRADR !== 12'o0100) begin miscompares++; $display("FAIL exec_cradr: got %o want 100", CRADR); end
      step();
      clear_fields();
      vectors++; if (CRADR !== 12'o0200) begin miscompares++; $display("FAIL jump: got %o want 200", CRADR); end
      vectors++; if (UINST_VALID !== 1'b0) begin miscompares++; $display("FAIL jump_fetch_uv: got %b want 0", UINST_VALID); end
   endtask

   task automatic test_skip();
      uop(12'o0300, 1'b0, 2'd0, 4'h0, 1'b1, 1'b1);
      vectors++; if (CRADR !== 12'o0301) begin miscompares++; $display("FAIL skip_taken: got %o want 301", CRADR); end
      uop(12'o0300, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0);
      vectors++; if (CRADR !== 12'o0300) begin miscompares++; $display("FAIL skip_not_taken: got %o want 300", CRADR); end
      // Condition true but skip disabled
      uop(12'o0300, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);
      vectors++; if (CRADR !== 12'o0300) begin miscompares++; $display("FAIL skip_disabled: got %o want 300", CRADR); end
   endtask

   task automatic test_dispatch_wait();
      int exec_cycles;
      uop(12'o0400, 1'b0, 2'd1, 4'b1010, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0412) begin miscompares++; $display("FAIL disp_or: got %o want 412", CRADR); end
      // Reserved mode behaves as no dispatch
      uop(12'o0400, 1'b0, 2'd3, 4'b1010, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0400) begin miscompares++; $display("FAIL disp_reserved: got %o want 400", CRADR); end
      // OR with overlapping bits: no carry
      uop(12'o0017, 1'b0, 2'd1, 4'b1001, 1'b1, 1'b1);
      vectors++; if (CRADR !== 12'o0017) begin miscompares++; $display("FAIL disp_nocarry: got %o want 17", CRADR); end
      J = 12'o0777; MB_WAIT = 1'b1;
      step();
      exec_cycles = UINST_VALID ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (UINST_VALID === 1'b1) exec_cycles++;
         vectors++; if (CRADR !== 12'o0017) begin miscompares++; $display("FAIL wait_hold[%0d]: got %o want 17", i, CRADR); end
      end
      MB_WAIT = 1'b0;
      step();
      clear_fields();
      vectors++; if (exec_cycles !== 4) begin miscompares++; $display("FAIL wait_exec_len: got %0d want 4", exec_cycles); end
      vectors++; if (CRADR !== 12'o0777) begin miscompares++; $display("FAIL wait_release: got %o want 777", CRADR); end
   endtask

   task automatic test_call_return();
      uop(12'o0500, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
      uop(12'o0600, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0600) begin miscompares++; $display("FAIL call_target: got %o want 600", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd1) begin miscompares++; $display("FAIL call_depth: got %0d want 1", STK_DEPTH); end
      uop(12'o0610, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
      uop(12'o7777, 1'b0, 2'd2, 4'd3, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0503) begin miscompares++; $display("FAIL ret_adr: got %o want 503", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd0) begin miscompares++; $display("FAIL ret_depth: got %0d want 0", STK_DEPTH); end
      uop(12'o0700, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
      // Call and return in one word: pop 0503, push 0700, depth stays 1
      uop(12'o0000, 1'b1, 2'd2, 4'h0, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0503) begin miscompares++; $display("FAIL callret_adr: got %o want 503", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd1) begin miscompares++; $display("FAIL callret_depth: got %0d want 1", STK_DEPTH); end
      uop(12'o0000, 1'b0, 2'd2, 4'd4, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0704) begin miscompares++; $display("FAIL callret_pop: got %o want 704", CRADR); end
   endtask

   task automatic test_stack_limits();
      do_start(12'o0000);
      for (int k = 0; k < 17; k++) uop(12'(k + 1), 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
`ifdef CRA_STACK_CHECK_EN
      vectors++; if (STK_DEPTH !== 7'd16) begin miscompares++; $display("FAIL ovf_depth: got %0d want 16", STK_DEPTH); end
      vectors++; if (STK_ERR !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", STK_ERR); end
`else
      vectors++; if (STK_DEPTH !== 7'd1) begin miscompares++; $display("FAIL wrap_depth: got %0d want 1", STK_DEPTH); end
      vectors++; if (STK_ERR !== 1'b0) begin miscompares++; $display("FAIL wrap_err: got %b want 0", STK_ERR); end
`endif
      do_start(12'o0040);
      vectors++; if (STK_DEPTH !== 7'd0) begin miscompares++; $display("FAIL start_clr_depth: got %0d want 0", STK_DEPTH); end
      uop(12'o1234, 1'b0, 2'd2, 4'd5, 1'b0, 1'b0);
`ifdef CRA_STACK_CHECK_EN
      vectors++; if (CRADR !== 12'o0005) begin miscompares++; $display("FAIL unf_adr: got %o want 5", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd0) begin miscompares++; $display("FAIL unf_depth: got %0d want 0", STK_DEPTH); end
      vectors++; if (STK_ERR !== 1'b1) begin miscompares++; $display("FAIL unf_err: got %b want 1", STK_ERR); end
`else
      // Wrapped pop rereads stale entry 15, written by the call issued at CRADR=15
      vectors++; if (CRADR !== 12'o0017) begin miscompares++; $display("FAIL unf_wrap_adr: got %o want 17", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd15) begin miscompares++; $display("FAIL unf_wrap_depth: got %0d want 15", STK_DEPTH); end
      vectors++; if (STK_ERR !== 1'b0) begin miscompares++; $display("FAIL unf_wrap_err: got %b want 0", STK_ERR); end
`endif
   endtask

   task automatic test_halt();
      J = 12'o0321; HALT = 1'b1; MB_WAIT = 1'b1;
      step();
      step();
      vectors++; if (RUNNING !== 1'b1 || UINST_VALID !== 1'b1) begin miscompares++; $display("FAIL halt_wait: got run=%b uv=%b want 1 1", RUNNING, UINST_VALID); end
      vectors++; if (CRADR === 12'o0321) begin miscompares++; $display("FAIL halt_wait_adr: got %o want not 321", CRADR); end
      MB_WAIT = 1'b0;
      step();
      clear_fields();
      vectors++; if (RUNNING !== 1'b0 || UINST_VALID !== 1'b0) begin miscompares++; $display("FAIL halt_idle: got run=%b uv=%b want 0 0", RUNNING, UINST_VALID); end
      vectors++; if (CRADR !== 12'o0321) begin miscompares++; $display("FAIL halt_adr: got %o want 321", CRADR); end
      J = 12'o0555; step(); step(); J = '0;
      vectors++; if (CRADR !== 12'o0321 || RUNNING !== 1'b0) begin miscompares++; $display("FAIL halt_stays: got %o run=%b want 321 0", CRADR, RUNNING); end
   endtask

   task automatic test_start_in_exec();
      do_start(12'o0100);
      uop(12'o0500, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
      vectors++; if (STK_DEPTH !== 7'd1) begin miscompares++; $display("FAIL pre_restart_depth: got %0d want 1", STK_DEPTH); end
      J = 12'o0222; MB_WAIT = 1'b1; HALT = 1'b1;
      step();
      START = 1'b1; START_ADR = 12'o1357;
      step();
      START = 1'b0; clear_fields();
      vectors++; if (CRADR !== 12'o1357) begin miscompares++; $display("FAIL restart_adr: got %o want 1357", CRADR); end
      vectors++; if (STK_DEPTH !== 7'd0) begin miscompares++; $display("FAIL restart_depth: got %0d want 0", STK_DEPTH); end
      vectors++; if (UINST_VALID !== 1'b0 || RUNNING !== 1'b1) begin miscompares++; $display("FAIL restart_fetch: got uv=%b run=%b want 0 1", UINST_VALID, RUNNING); end
   endtask

   task automatic test_reset_mid_fetch();
      uop(12'o0444, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0);
      #2;
      RESET = 1'b1;
      #1;
      vectors++; if (CRADR !== 12'o0 || UINST_VALID !== 1'b0 || RUNNING !== 1'b0) begin miscompares++; $display("FAIL async_reset: got %o uv=%b run=%b want 0 0 0", CRADR, UINST_VALID, RUNNING); end
      vectors++; if (STK_DEPTH !== 7'd0 || STK_ERR !== 1'b0) begin miscompares++; $display("FAIL async_reset_stk: got depth=%0d err=%b want 0 0", STK_DEPTH, STK_ERR); end
      step();
      RESET = 1'b0;
      step();
      // Stack entries are cleared by reset: a wrapped/underflow pop yields only DISP_DATA
      do_start(12'o0010);
      uop(12'o0000, 1'b0, 2'd2, 4'd6, 1'b0, 1'b0);
      vectors++; if (CRADR !== 12'o0006) begin miscompares++; $display("FAIL reset_stack_clear: got %o want 6", CRADR); end
   endtask

   initial begin
      test_reset();
      test_start_jump();
      test_skip();
      test_dispatch_wait();
      test_call_return();
      test_stack_limits();
      test_halt();
      test_start_in_exec();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
